// File: rtl/wb_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM states and the
// master request / slave response bundles.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        ABORT = 2'd3
    } wb_state_e;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        lock;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_req_t;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic [31:0] dat;
    } wb_rsp_t;

    localparam int WDOG_W = 16;

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog: counts strobed cycles without a response and flags a
// timeout at TIMEOUT-1; also keeps the saturating abort counter.
module wb_watchdog
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ERRW    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            active_i,
    input  logic            stb_i,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic            state_chg_i,
    input  logic            abort_i,
    output logic            timeout_o,
    output logic [ERRW-1:0] abort_count_o
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] count_q, count_d;
    logic [ERRW-1:0]   aborts_q, aborts_d;
    logic              stalled;

    // A response in the threshold cycle suppresses the timeout.
    assign stalled   = active_i && stb_i && !ack_i && !err_i;
    assign timeout_o = stalled && (count_q == LIMIT);

    always_comb begin
        count_d  = '0;
        aborts_d = aborts_q;
        if (stalled && !state_chg_i) begin
            count_d = count_q + WDOG_W'(1);
        end
        if (abort_i && (aborts_q != {ERRW{1'b1}})) begin
            aborts_d = aborts_q + ERRW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            aborts_q <= '0;
        end else begin
            count_q  <= count_d;
            aborts_q <= aborts_d;
        end
    end

    assign abort_count_o = aborts_q;

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between the video
// store path (master 0) and fetch path (master 1), with LOCK and watchdog.
module wb_master_arbiter
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ERRW    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_CYC_I,
    input  logic            m0_STB_I,
    input  logic            m0_LOCK_I,
    input  logic            m0_WE_I,
    input  logic [3:0]      m0_SEL_I,
    input  logic [31:0]     m0_ADR_I,
    input  logic [31:0]     m0_DAT_I,
    output logic            m0_ACK_O,
    output logic            m0_ERR_O,
    output logic [31:0]     m0_DAT_O,
    input  logic            m1_CYC_I,
    input  logic            m1_STB_I,
    input  logic            m1_LOCK_I,
    input  logic            m1_WE_I,
    input  logic [3:0]      m1_SEL_I,
    input  logic [31:0]     m1_ADR_I,
    input  logic [31:0]     m1_DAT_I,
    output logic            m1_ACK_O,
    output logic            m1_ERR_O,
    output logic [31:0]     m1_DAT_O,
    output logic            p_wb_CYC_O,
    output logic            p_wb_STB_O,
    output logic            p_wb_LOCK_O,
    output logic            p_wb_WE_O,
    output logic [3:0]      p_wb_SEL_O,
    output logic [31:0]     p_wb_ADR_O,
    output logic [31:0]     p_wb_DAT_O,
    input  logic            p_wb_ACK_I,
    input  logic            p_wb_ERR_I,
    input  logic [31:0]     p_wb_DAT_I,
    output logic [1:0]      grant,
    output logic [ERRW-1:0] abort_count,
    output wb_state_e       state_o
);

    // Handshake: a master owns the bus from grant until it drops CYC with
    // LOCK low; STB is held until ACK or ERR, which pass through unregistered.

    wb_state_e state_q, state_d;
    logic      last_q, last_d;
    wb_req_t   req0, req1, bus;
    wb_rsp_t   p_rsp, rsp0, rsp1;
    logic      timeout;

    assign req0  = {m0_CYC_I, m0_STB_I, m0_LOCK_I, m0_WE_I, m0_SEL_I, m0_ADR_I, m0_DAT_I};
    assign req1  = {m1_CYC_I, m1_STB_I, m1_LOCK_I, m1_WE_I, m1_SEL_I, m1_ADR_I, m1_DAT_I};
    assign p_rsp = {p_wb_ACK_I, p_wb_ERR_I, p_wb_DAT_I};

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                // On a tie the master that did not own the bus last wins.
                if (req0.cyc && (!req1.cyc || last_q)) begin
                    state_d = OWN0;
                end else if (req1.cyc) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!req0.cyc && !req0.lock) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end else if (timeout) begin
                    state_d = ABORT;
                    last_d  = 1'b0;
                end
            end
            OWN1: begin
                if (!req1.cyc && !req1.lock) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end else if (timeout) begin
                    state_d = ABORT;
                    last_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        bus  = '0;
        rsp0 = '0;
        rsp1 = '0;
        case (state_q)
            OWN0: begin
                bus  = req0;
                rsp0 = p_rsp;
            end
            OWN1: begin
                bus  = req1;
                rsp1 = p_rsp;
            end
            // last_q already names the aborted owner while in ABORT.
            ABORT: begin
                if (last_q) rsp1.err = 1'b1;
                else        rsp0.err = 1'b1;
            end
            default: ;
        endcase
    end

    wb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .ERRW    (ERRW)
    ) u_watchdog (
        .clk           (clk),
        .reset         (reset),
        .active_i      ((state_q == OWN0) || (state_q == OWN1)),
        .stb_i         (bus.stb),
        .ack_i         (p_wb_ACK_I),
        .err_i         (p_wb_ERR_I),
        .state_chg_i   (state_d != state_q),
        .abort_i       (state_q == ABORT),
        .timeout_o     (timeout),
        .abort_count_o (abort_count)
    );

    assign p_wb_CYC_O  = bus.cyc;
    assign p_wb_STB_O  = bus.stb;
    assign p_wb_LOCK_O = bus.lock;
    assign p_wb_WE_O   = bus.we;
    assign p_wb_SEL_O  = bus.sel;
    assign p_wb_ADR_O  = bus.adr;
    assign p_wb_DAT_O  = bus.dat;

    assign m0_ACK_O = rsp0.ack;
    assign m0_ERR_O = rsp0.err;
    assign m0_DAT_O = rsp0.dat;
    assign m1_ACK_O = rsp1.ack;
    assign m1_ERR_O = rsp1.err;
    assign m1_DAT_O = rsp1.dat;

    assign grant   = {state_q == OWN1, state_q == OWN0};
    assign state_o = state_q;

endmodule

// File: doc/wb_master_arbiter.md
# wb_master_arbiter

Two-master Wishbone arbiter that shares the single system-bus master port between the video input path (store side, master 0) and the video output path (fetch side, master 1). It grants whole bus cycles with round-robin fairness, honours LOCK, and runs a watchdog that terminates stalled cycles with ERR. It sits between the two video masters and the SoC bus interconnect, in the 100 MHz system clock domain.

## Interface
- TIMEOUT, 255: system-clock cycles a strobed access may wait for ACK/ERR before the watchdog aborts it (1..65535).
- ERRW, 8: width of the saturating abort counter.
- clk  in  1  system clock, 100 MHz.
- reset  in  1  reset; one clock, reset is synchronous and active-high.
- mN_CYC_I, mN_STB_I, mN_LOCK_I, mN_WE_I  in  1 each  master N cycle, strobe, lock and write-enable (N = 0, 1).
- mN_SEL_I  in  4  master N byte select.
- mN_ADR_I, mN_DAT_I  in  32 each  master N address and write data.
- mN_ACK_O, mN_ERR_O  out  1 each  master N acknowledge and error.
- mN_DAT_O  out  32  master N read data.
- p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O, p_wb_WE_O  out  1 each  shared bus master controls.
- p_wb_SEL_O  out  4; p_wb_ADR_O, p_wb_DAT_O  out  32 each  shared bus select, address, write data.
- p_wb_ACK_I, p_wb_ERR_I  in  1 each; p_wb_DAT_I  in  32  shared bus responses and read data.
- grant  out  2  one-hot current owner (bit N = master N), 00 when idle.
- abort_count  out  ERRW  saturating count of watchdog aborts.

## Operation
- States: IDLE, OWN0, OWN1, ABORT.
- IDLE: no master is routed. If mN_CYC_I is asserted, the state moves to OWNN on the next edge. If both request, the master that is not `last` wins. `last` is the owner of the most recent grant; its reset value is 1, so master 0 wins the first tie.
- OWNN: all p_wb_* outputs are muxed from master N. mN_ACK_O = p_wb_ACK_I, mN_ERR_O = p_wb_ERR_I, mN_DAT_O = p_wb_DAT_I.
- The non-owner sees ACK = ERR = 0 and DAT_O = 0. Its requests are held off and never dropped.
- Release: when the owner has mN_CYC_I = 0 and mN_LOCK_I = 0, the state goes to IDLE on the next edge and `last` is set to N.
- If CYC is 0 but LOCK is still 1, the grant is kept, so a locked read-modify-write sequence stays atomic.
- Watchdog: a 16-bit counter increments on each cycle with the owner's STB = 1 and both p_wb_ACK_I and p_wb_ERR_I = 0. It clears on ACK, on ERR, on STB = 0, and on any state change.
- When the counter reaches TIMEOUT-1 with no response, the next state is ABORT.
- ABORT (exactly one cycle):
  - all p_wb_* outputs = 0;
  - mN_ERR_O = 1 to the former owner only;
  - abort_count increments and saturates at all-ones;
  - `last` = N;
  - the next state is IDLE.
- Aborted masters must drop CYC. If the former owner still asserts CYC in IDLE, it re-arbitrates normally.
- The arbiter never decodes addresses and never alters SEL, WE or data.

## Timing
- Reset values: every output is 0, grant = 00, abort_count = 0, state = IDLE, counter = 0, `last` = 1.
- Grant latency: CYC rising in cycle k (bus idle) gives grant and p_wb_CYC_O in cycle k+1. The master must hold STB until ACK, which is standard Wishbone.
- Responses are combinational pass-through in the owner state: zero added latency on ACK, ERR and read data.
- Turnaround: owner CYC falling in cycle k gives IDLE in k+1. The other master's grant appears in k+2 at the earliest. This guarantees one idle bus cycle between owners.
- Simultaneous events:
  - ACK/ERR in the same cycle as the timeout threshold: the response wins and the counter clears, with no abort.
  - Release and a new request in the same cycle: the release completes first, then arbitration in IDLE.
- Reset mid-cycle takes effect at the next edge: all bus outputs drop and any in-flight transfer is abandoned without ERR.

## Structure
- Shared package wb_pkg:
  - state typedef (IDLE, OWN0, OWN1, ABORT);
  - a wishbone master request struct {cyc, stb, lock, we, sel[3:0], adr[31:0], dat[31:0]};
  - a response struct {ack, err, dat[31:0]}.
- One natural sub-module, wb_watchdog: the counter, the threshold compare, the clear logic, and the saturating abort_count.
- The FSM and muxes stay in the top module.

## Test plan
- Single request: m0 CYC/STB at cycle 1, slave ACK at cycle 4 → grant = 01 at cycle 2, m0_ACK_O = 1 at cycle 4, IDLE at cycle 6 after CYC drops at cycle 5.
- Tie from reset: both CYC rise together → m0 served first. After m0 releases, m1 is granted 2 cycles later. A repeated simultaneous request is served m0, m1, m0 in alternation.
- LOCK hold: m1 owns, drops CYC while LOCK = 1, m0 requesting → grant stays 10 until LOCK falls, then m0 is granted 2 cycles later.
- Watchdog: TIMEOUT = 8, slave never acks → the state enters ABORT after 8 strobed cycles. This gives a one-cycle m0_ERR_O pulse, p_wb_CYC_O = 0, and abort_count goes 0 → 1.
- Response at the threshold: ACK arrives exactly on the cycle the counter hits TIMEOUT-1 → normal ACK, no ERR, abort_count unchanged. With ERRW = 2, 5 aborts leave abort_count = 3.
- Reset during an m1 write burst → next edge: all outputs 0, grant = 00. After reset deasserts, a pending m0 request wins.
